// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_CYCLES,
// then performs the RV32I-width access on its internal RAM and returns one response.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [2:0]            funct3_q;

    logic [31:0]           mem [MEM_WORDS];

    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  f3_ok;
    logic                  aligned;
    logic                  access_err;
    logic                  do_access;
    logic                  do_write;
    logic [31:0]           cur_word;
    logic [31:0]           new_word;
    logic [7:0]            sel_byte;
    logic [15:0]           sel_half;
    logic [DATA_WIDTH-1:0] load_val;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = WAIT;
            WAIT:    if (cnt == '0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decode the latched request: legality, lane selection, load extension and store merge.
    always_comb begin
        idx      = addr_q[IDX_W+1:2];
        in_range = (addr_q[DATA_WIDTH-1:2] < (DATA_WIDTH-2)'(MEM_WORDS));
        cur_word = in_range ? mem[idx] : '0;

        case (addr_q[1:0])
            2'd0:    sel_byte = cur_word[7:0];
            2'd1:    sel_byte = cur_word[15:8];
            2'd2:    sel_byte = cur_word[23:16];
            default: sel_byte = cur_word[31:24];
        endcase
        sel_half = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

        f3_ok   = 1'b0;
        aligned = 1'b1;
        case (funct3_q)
            3'b000: f3_ok = 1'b1;
            3'b001: begin f3_ok = 1'b1;   aligned = ~addr_q[0];          end
            3'b010: begin f3_ok = 1'b1;   aligned = (addr_q[1:0] == 2'b00); end
            3'b100: f3_ok = ~we_q;
            3'b101: begin f3_ok = ~we_q;  aligned = ~addr_q[0];          end
            default: f3_ok = 1'b0;
        endcase
        access_err = ~(f3_ok & aligned & in_range);

        case (funct3_q)
            3'b000:  load_val = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
            3'b001:  load_val = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
            3'b010:  load_val = DATA_WIDTH'(cur_word);
            3'b100:  load_val = DATA_WIDTH'(sel_byte);
            3'b101:  load_val = DATA_WIDTH'(sel_half);
            default: load_val = '0;
        endcase

        // Stores are read-modify-write so untouched byte lanes keep their value.
        new_word = cur_word;
        case (funct3_q[1:0])
            2'b00:   new_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01:   new_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            2'b10:   new_word = wdata_q[31:0];
            default: new_word = cur_word;
        endcase

        do_access = (state == WAIT) && (cnt == '0);
        do_write  = do_access && we_q && !access_err;
    end

    always_ff @(posedge clk) begin
        if (do_write && rst) mem[idx] <= new_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        funct3_q <= req_funct3;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_err   <= access_err;
                        rsp_rdata <= (access_err || we_q) ? '0 : load_val;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
